mouse_sprite_overlay: RTL
=========================

# mouse_sprite_overlay

Per-pixel overlay stage directly downstream of the mouse-pointer sprite RAM. It holds a frame-stable pointer position and drives the sprite RAM read address from the video pixel coordinates. It then maps the returned 2-bit colour index through a writable 4-entry palette and muxes the result over the background RGB stream. All pixel sideband is delayed to match the RAM's one-cycle read latency.

## Interface
- `CD`, 12: colour depth of background and output RGB.
- `XW`, 11: width of pixel x coordinate and pointer x position.
- `YW`, 11: width of pixel y coordinate and pointer y position.
- `SPR_LOG2`, 5: log2 of the sprite side; the sprite is 32x32. Sprite RAM address width is 2*SPR_LOG2 = 10.
- `clk`  in  1: single clock; all logic rising-edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `x`, `y`  in  XW / YW: current pixel coordinates.
- `pix_valid`  in  1: pixel coordinates and `bg_rgb` are valid this cycle.
- `bg_rgb`  in  CD: background colour for this pixel.
- `frame_start`  in  1: one-cycle pulse, asserted once per frame during blanking.
- `pos_wr`  in  1: strobe that loads `pos_x_in` / `pos_y_in` into the pending position.
- `pos_x_in`, `pos_y_in`  in  XW / YW: new pointer top-left corner.
- `en_in`  in  1: overlay enable; committed together with the position.
- `pal_we`  in  1: palette write strobe.
- `pal_addr`  in  2: palette entry to write; entry 0 is ignored.
- `pal_data`  in  CD: palette write data.
- `spr_addr`  out  2*SPR_LOG2: sprite RAM read address (`addr_r`). Combinational from `x`, `y` and the active position.
- `spr_data`  in  2: sprite RAM read data (`dout`), valid one cycle after the address.
- `rgb_out`  out  CD: composited pixel colour.
- `rgb_valid`  out  1: `pix_valid` delayed to match `rgb_out`.

## Operation
- **Position registers.**
  - Pending position and enable: loaded on `pos_wr`.
  - Active position and enable: loaded from pending on `frame_start`.
  - If `pos_wr` and `frame_start` occur in the same cycle, the active set takes `pos_*_in`/`en_in` directly (bypass).
  - Mid-frame `pos_wr` never alters the current frame's active position.
- **Hit test.**
  - dx = x - act_x and dy = y - act_y, each computed one bit wider than its operand.
  - hit = act_en & pix_valid & (x >= act_x) & (y >= act_y) & (dx < 32) & (dy < 32).
  - A pointer placed partly beyond the screen edge is simply clipped; there is no wrap.
- **Address.**
  - `spr_addr` = {dy[4:0], dx[4:0]}, row-major.
  - Driven with the masked offsets whatever the value of hit; the data is ignored when hit = 0.
- **Stage 1** (registered): hit_d, bg_rgb_d, valid_d.
- **Composite.**
  - Index = `spr_data`. Index 0 is transparent.
  - If hit_d and index != 0, the output is pal[index]; otherwise the output is bg_rgb_d.
  - The result is registered into `rgb_out`; `rgb_valid` <= valid_d.
- **Palette.**
  - Entries 1..3 are registers.
  - Writes with `pal_addr` = 0 have no effect.
  - Reset values: pal[1] = 0x000, pal[2] = all ones, pal[3] = 0xF00 (MSB nibble set, scaled to CD).
- **Reset values.** `rgb_out` = 0, `rgb_valid` = 0, all stage registers 0, pending and active positions 0, enables 0 (overlay off).

## Timing
- Latency from `x`/`y`/`bg_rgb`/`pix_valid` to `rgb_out`/`rgb_valid` is fixed at 2 cycles. Throughput is 1 pixel per cycle; there is no stall and no backpressure.
- `spr_addr` is combinational in cycle t; `spr_data` arrives in cycle t+1; the composite is registered at the t+2 edge.
- A palette write at edge e affects any pixel whose composite is registered at edge e+1 or later.
- A `frame_start` at edge e affects pixels presented in cycle e+1 or later.
- Reset asserted mid-line:
  - Outputs clear immediately (asynchronous).
  - After release, `rgb_valid` stays 0 until 2 cycles after the next `pix_valid`.

## Structure
- Shared package `mouse_pkg` holds:
  - `SPR_LOG2`, `SPR_SIZE`, `CD`;
  - `TRANSPARENT_IDX` = 2'd0;
  - `pal_idx_t` (2-bit);
  - `rgb_t`;
  - palette reset constants.
- One natural sub-module: `mouse_palette_regs`, the 3-entry write port with combinational read by index.
- Hit/address logic and the pipeline stay in the top module.

## Test plan
- **Basic hit.** Commit pos (100, 50), en = 1, RAM model returns index 2 at address {5'd3, 5'd4}. Present x = 104, y = 53 -> `spr_addr` = 0x064 the same cycle; 2 cycles later `rgb_out` = all ones, `rgb_valid` = 1.
- **Transparency and miss.**
  - Index 0 inside the box -> `rgb_out` = `bg_rgb` (e.g. 0x0A5).
  - x = 132, y = 53 (dx = 32) -> background.
  - x = 99 -> background.
- **Edge clip.** Pos (630, 470) on a 640x480 stream: pixels x >= 640 and y >= 480 never occur, no wrap hit at x = 0; pixel (639, 479) uses address {5'd9, 5'd9}.
- **Frame-synchronous commit.** Issue `pos_wr` (200, 200) mid-frame -> the old position persists until `frame_start`. Same-cycle `pos_wr` + `frame_start` -> the new position is active from the next pixel.
- **Palette write.** `pal_we` to entry 3 with 0x0F0, then hit pixels with index 3 -> 0x0F0. A write to entry 0 -> index-0 pixels remain transparent.
- **Reset.** Assert `rst_n` = 0 during hit pixels -> `rgb_out` = 0 and `rgb_valid` = 0 immediately. After release with no commit, en = 0, so every pixel passes background through at 2-cycle latency.

Source files
------------

// File: rtl/mouse_pkg.sv
// Shared types and constants for the mouse-pointer sprite overlay.
package mouse_pkg;

    localparam int unsigned SPR_LOG2 = 5;
    localparam int unsigned SPR_SIZE = 1 << SPR_LOG2;
    localparam int unsigned CD       = 12;

    typedef logic [1:0]    pal_idx_t;
    typedef logic [CD-1:0] rgb_t;

    localparam pal_idx_t TRANSPARENT_IDX = 2'd0;

    // Palette reset values; entry 3 sets only the MSB nibble, whatever the depth.
    localparam rgb_t       PAL1_RST     = '0;
    localparam rgb_t       PAL2_RST     = '1;
    localparam logic [3:0] PAL3_MSB_NIB = 4'hF;
    localparam rgb_t       PAL3_RST     = {PAL3_MSB_NIB, {(CD - 4){1'b0}}};

endpackage

// File: rtl/mouse_palette_regs.sv
// Three writable pointer colours with a combinational read by colour index.
module mouse_palette_regs #(
    parameter int unsigned CD = mouse_pkg::CD
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  mouse_pkg::pal_idx_t waddr,
    input  logic [CD-1:0]       wdata,
    input  mouse_pkg::pal_idx_t ridx,
    output logic [CD-1:0]       rdata_c
);

    localparam logic [CD-1:0] RST1 = '0;
    localparam logic [CD-1:0] RST2 = '1;
    localparam logic [CD-1:0] RST3 = {mouse_pkg::PAL3_MSB_NIB, {(CD - 4){1'b0}}};

    logic [CD-1:0] pal1, pal2, pal3;

    // Entry 0 is the transparent index and has no storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pal1 <= RST1;
            pal2 <= RST2;
            pal3 <= RST3;
        end else if (we) begin
            case (waddr)
                2'd1:    pal1 <= wdata;
                2'd2:    pal2 <= wdata;
                2'd3:    pal3 <= wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata_c = '0;
        case (ridx)
            2'd1:    rdata_c = pal1;
            2'd2:    rdata_c = pal2;
            2'd3:    rdata_c = pal3;
            default: rdata_c = '0;
        endcase
    end

endmodule

// File: rtl/mouse_sprite_overlay.sv
// Pointer hit test, sprite RAM addressing and palette composite over the background
// stream; two-cycle fixed latency matching a one-cycle sprite RAM read.
module mouse_sprite_overlay #(
    parameter int unsigned CD       = mouse_pkg::CD,
    parameter int unsigned XW       = 11,
    parameter int unsigned YW       = 11,
    parameter int unsigned SPR_LOG2 = mouse_pkg::SPR_LOG2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [XW-1:0]         x,
    input  logic [YW-1:0]         y,
    input  logic                  pix_valid,
    input  logic [CD-1:0]         bg_rgb,
    input  logic                  frame_start,
    input  logic                  pos_wr,
    input  logic [XW-1:0]         pos_x_in,
    input  logic [YW-1:0]         pos_y_in,
    input  logic                  en_in,
    input  logic                  pal_we,
    input  logic [1:0]            pal_addr,
    input  logic [CD-1:0]         pal_data,
    output logic [2*SPR_LOG2-1:0] spr_addr,
    input  logic [1:0]            spr_data,
    output logic [CD-1:0]         rgb_out,
    output logic                  rgb_valid
);

    localparam int unsigned SIDE   = 1 << SPR_LOG2;
    localparam logic [XW:0] SIDE_X = (XW + 1)'(SIDE);
    localparam logic [YW:0] SIDE_Y = (YW + 1)'(SIDE);

    logic [XW-1:0] pend_x, act_x;
    logic [YW-1:0] pend_y, act_y;
    logic          pend_en, act_en;

    // Pending set follows the CPU; active set only changes at frame boundaries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_x  <= '0;
            pend_y  <= '0;
            pend_en <= 1'b0;
            act_x   <= '0;
            act_y   <= '0;
            act_en  <= 1'b0;
        end else begin
            if (pos_wr) begin
                pend_x  <= pos_x_in;
                pend_y  <= pos_y_in;
                pend_en <= en_in;
            end
            if (frame_start) begin
                act_x  <= pos_wr ? pos_x_in : pend_x;
                act_y  <= pos_wr ? pos_y_in : pend_y;
                act_en <= pos_wr ? en_in    : pend_en;
            end
        end
    end

    // A negative offset shows up as the extra top bit, so no wrap into the box.
    logic [XW:0] dx;
    logic [YW:0] dy;
    logic        in_x_c, in_y_c, hit_c;

    always_comb begin
        dx       = {1'b0, x} - {1'b0, act_x};
        dy       = {1'b0, y} - {1'b0, act_y};
        in_x_c   = !dx[XW] && (dx < SIDE_X);
        in_y_c   = !dy[YW] && (dy < SIDE_Y);
        hit_c    = act_en && pix_valid && in_x_c && in_y_c;
        spr_addr = {dy[SPR_LOG2-1:0], dx[SPR_LOG2-1:0]};
    end

    logic          hit_d, valid_d;
    logic [CD-1:0] bg_rgb_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_d    <= 1'b0;
            valid_d  <= 1'b0;
            bg_rgb_d <= '0;
        end else begin
            hit_d    <= hit_c;
            valid_d  <= pix_valid;
            bg_rgb_d <= bg_rgb;
        end
    end

    logic [CD-1:0] pal_rgb_c;

    mouse_palette_regs #(.CD(CD)) u_palette (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (pal_we),
        .waddr   (pal_addr),
        .wdata   (pal_data),
        .ridx    (spr_data),
        .rdata_c (pal_rgb_c)
    );

    logic          spr_sel_c;
    logic [CD-1:0] comp_c;

    always_comb begin
        spr_sel_c = hit_d && (spr_data != mouse_pkg::TRANSPARENT_IDX);
        comp_c    = spr_sel_c ? pal_rgb_c : bg_rgb_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_out   <= '0;
            rgb_valid <= 1'b0;
        end else begin
            rgb_out   <= comp_c;
            rgb_valid <= valid_d;
        end
    end

endmodule
